pipeline_reg_chain: RTL
=======================

Name: pipeline_reg_chain

Overview:
- Parametrised chain of NUM_STAGES valid/ready register slices between one producer and one consumer.
- Generalises the single-stage pipeline register with configurable depth and stage type: a forward-registered stage or a fully-registered skid stage.
- Adds a synchronous flush.
- Used to break long timing paths on streaming datapaths without losing throughput.

Parameters:
- DATA_WIDTH, 32, payload width in bits (>=1).
- NUM_STAGES, 2, number of register slices in series (>=1).
- SKID_MODE, 0. 0 = forward-registered stages (combinational ready path). 1 = skid stages (both valid and ready registered).

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous flush; drops all held data
- in_valid  in  1  producer data valid
- in_ready  out  1  chain can accept in_data this cycle
- in_data  in  DATA_WIDTH  producer payload
- out_valid  out  1  chain holds valid data at the output
- out_ready  in  1  consumer accepts this cycle
- out_data  out  DATA_WIDTH  consumer payload
- occupancy  out  $clog2(2*NUM_STAGES+1)  number of held beats (present only with PIPE_OCCUPANCY_EN)

Behaviour:
- Reset (async assert, sync-safe deassert): all stage valid and skid valid bits = 0, all data registers = 0.
  - out_valid = 0, out_data = 0, occupancy = 0.
  - in_ready = 1 in both modes.
- Transfer rule: a beat moves on an interface when valid && ready are both high at a rising edge. Data is never duplicated, dropped (except on flush) or reordered.
- Stage i output feeds stage i+1 input. Stage 0 faces the producer; stage NUM_STAGES-1 faces the consumer.
- SKID_MODE=0 stage:
  - ready_up = ~valid || ready_down (combinational).
  - On an accepted input: load data, set valid. Else if valid && ready_down: clear valid.
  - Capacity: 1 beat per stage.
- SKID_MODE=1 stage (main reg + skid reg):
  - ready_up = ~skid_valid, registered; no combinational path from out_ready to in_ready.
  - If main is empty or ready_down: main loads from skid when skid_valid (and skid clears), otherwise from the upstream input if accepted.
  - If an upstream beat is accepted while main is full and ~ready_down: the beat goes into skid.
  - Capacity: 2 beats per stage.
- Latency: an accepted beat into an empty chain appears at out_valid exactly NUM_STAGES cycles later.
- Throughput: 1 beat/cycle sustained in both modes when out_ready stays 1.
- Backpressure:
  - out_ready = 0 holds out_data/out_valid stable until accepted.
  - The chain fills until in_ready = 0: after NUM_STAGES beats (mode 0) or 2*NUM_STAGES beats (mode 1).
- Flush:
  - In the flush cycle in_ready = 0 and out_valid = 0, so no transfer occurs on either side.
  - At the next edge all valid/skid bits clear. Data registers may keep stale values.
  - flush has priority over every concurrent event.
- Simultaneous accept and drain on a full stage: accept and drain both occur, occupancy is unchanged, and the new beat takes the slot.
- Reset asserted mid-stream: all held beats are discarded immediately; no output beat appears before new input.

Optional Feature:
- PIPE_OCCUPANCY_EN defined:
  - Adds the occupancy port, a registered count of held beats.
  - +1 per accepted input, -1 per accepted output, unchanged when both occur in one cycle.
  - Cleared to 0 by reset or flush.
  - Saturation is impossible by construction; the bench asserts that occupancy never exceeds capacity.
- PIPE_OCCUPANCY_EN undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- NUM_STAGES=3, SKID_MODE=0, out_ready=1, push 0x11,0x22,0x33 on consecutive cycles -> out_data 0x11 appears 3 cycles after its accept, then 0x22 and 0x33 back-to-back; in_ready stays 1.
- NUM_STAGES=2, SKID_MODE=1, out_ready=0, continuous in_valid with data 1..6 -> exactly 4 beats accepted, then in_ready=0; on out_ready=1, output 1,2,3,4 in order with no bubbles.
- SKID_MODE=1, out_ready toggled every cycle while streaming 0..99 -> all 100 beats delivered in order, no loss/dup; in_ready never depends combinationally on out_ready (checked with a same-cycle out_ready flip).
- Chain holds 2 beats, flush=1 for one cycle with in_valid=1 -> no input accepted that cycle; out_valid=0 next cycle; occupancy=0 (with PIPE_OCCUPANCY_EN).
- Reset asserted mid-transfer with 3 beats held -> out_valid=0 and out_data=0 immediately; in_ready=1 after release; the first post-reset beat is delivered correctly.
- Random valid/ready stimulus, both modes, NUM_STAGES in {1,4}, scoreboard check -> in-order exact delivery; occupancy equals beats in minus beats out every cycle.

Source files
------------

// File: rtl/pipeline_reg_chain.sv
// Chain of NUM_STAGES valid/ready register slices (forward-registered or skid) with synchronous flush.
// Optional occupancy counter port is built when PIPE_OCCUPANCY_EN is defined.
module pipeline_reg_chain #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_STAGES = 2,
  parameter int SKID_MODE  = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data
`ifdef PIPE_OCCUPANCY_EN
  ,
  output logic [$clog2(2*NUM_STAGES+1)-1:0] occupancy
`endif
);

  // Each slice exposes its upstream ready and downstream valid/data; neighbours
  // are linked by name so no shared vector carries a bit-to-bit combinational chain.
  for (genvar i = 0; i < NUM_STAGES; i++) begin : g_stage
    logic                  vin;
    logic [DATA_WIDTH-1:0] din;
    logic                  rdn;
    logic                  rup;
    logic                  vout;
    logic [DATA_WIDTH-1:0] dout;

    if (i == 0) begin : g_head
      assign vin = in_valid;
      assign din = in_data;
    end else begin : g_link
      assign vin = g_stage[i-1].vout;
      assign din = g_stage[i-1].dout;
    end

    if (i == NUM_STAGES - 1) begin : g_tail
      assign rdn = out_ready;
    end else begin : g_next
      assign rdn = g_stage[i+1].rup;
    end

    if (SKID_MODE == 0) begin : g_fwd
      logic                  vld_q;
      logic [DATA_WIDTH-1:0] dat_q;

      assign rup  = ~vld_q | rdn;
      assign vout = vld_q;
      assign dout = dat_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_q <= 1'b0;
          dat_q <= '0;
        end else if (flush) begin
          vld_q <= 1'b0;
        end else if (vin && rup) begin
          vld_q <= 1'b1;
          dat_q <= din;
        end else if (rdn) begin
          vld_q <= 1'b0;
        end
      end
    end else begin : g_skid
      logic                  main_vld;
      logic                  skid_vld;
      logic [DATA_WIDTH-1:0] main_dat;
      logic [DATA_WIDTH-1:0] skid_dat;
      logic                  accept;

      // Upstream ready comes straight from a flop, cutting the ready path.
      assign rup    = ~skid_vld;
      assign vout   = main_vld;
      assign dout   = main_dat;
      assign accept = vin & ~skid_vld;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          main_vld <= 1'b0;
          skid_vld <= 1'b0;
          main_dat <= '0;
          skid_dat <= '0;
        end else if (flush) begin
          main_vld <= 1'b0;
          skid_vld <= 1'b0;
        end else if (!main_vld || rdn) begin
          if (skid_vld) begin
            main_dat <= skid_dat;
            main_vld <= 1'b1;
            skid_vld <= 1'b0;
          end else if (accept) begin
            main_dat <= din;
            main_vld <= 1'b1;
          end else begin
            main_vld <= 1'b0;
          end
        end else if (accept) begin
          skid_dat <= din;
          skid_vld <= 1'b1;
        end
      end
    end
  end

  // Flush blocks both interfaces for its cycle so no beat is half-transferred.
  assign in_ready  = g_stage[0].rup & ~flush;
  assign out_valid = g_stage[NUM_STAGES-1].vout & ~flush;
  assign out_data  = g_stage[NUM_STAGES-1].dout;

`ifdef PIPE_OCCUPANCY_EN
  localparam int OCC_W = $clog2(2*NUM_STAGES+1);

  logic in_fire;
  logic out_fire;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occupancy <= '0;
    end else if (flush) begin
      occupancy <= '0;
    end else if (in_fire && !out_fire) begin
      occupancy <= occupancy + OCC_W'(1);
    end else if (out_fire && !in_fire) begin
      occupancy <= occupancy - OCC_W'(1);
    end
  end
`else
  // No occupancy tracking in this build.
`endif

endmodule
